stereo_echo_dsp: RTL

// - Fast-domain stereo echo stage. Sits between the Rx slow-to-fast CDC pair and the Tx fast-to-slow CDC pair.
// - Per frame: reads a delayed sample per channel from a circular buffer, mixes it into the dry input,

---
 rtl/stereo_echo_dsp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stereo_echo_dsp.sv
// rtl/stereo_echo_dsp.sv - fast-domain stereo echo stage with circular delay buffers
// Define ECHO_FEEDBACK_EN to enable the fb_gain write-back path; otherwise history is always the dry input.
module stereo_echo_dsp #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11,
  parameter int GAIN_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_left,
  input  logic [WIDTH-1:0]  in_right,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [GAIN_W-1:0] wet_gain,
  input  logic [GAIN_W-1:0] fb_gain,
  input  logic              bypass,
  input  logic              overrun_clr,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_left,
  output logic [WIDTH-1:0]  out_right,
  output logic              busy,
  output logic              overrun
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = WIDTH + GAIN_W + 1;

  typedef enum logic [1:0] {IDLE, RD, MAC, WR} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]  dry_l, dry_r, rd_l, rd_r, wb_l, wb_r, mix_l, mix_r;
  logic [ADDR_W-1:0] d_reg, d_in, rd_addr, wr_ptr;
  logic [ADDR_W:0]   fill_cnt;
  logic [GAIN_W-1:0] wet_g;
  logic              byp, del_zero, accept;
  logic signed [PW-1:0] del_lx, del_rx, wet_x, pw_l, pw_r;

  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Sign-extend dry to WIDTH+1, add the product scaled down by GAIN_W (arith), then clamp.
  function automatic logic [WIDTH-1:0] mix(input logic [WIDTH-1:0] dry, input logic [PW-1:0] p);
    logic signed [WIDTH:0] s;
    s = $signed({dry[WIDTH-1], dry}) + $signed(p[PW-1:GAIN_W]);
    if (s[WIDTH] != s[WIDTH-1])
      mix = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      mix = s[WIDTH-1:0];
  endfunction

  assign accept = in_valid && (state == IDLE);
  assign busy   = (state != IDLE);
  assign d_in   = (delay_len == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : delay_len;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RD;
      RD:      state_nx = MAC;
      MAC:     state_nx = WR;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Buffers have no reset so they map onto block RAM; the read port is free-running.
  always_ff @(posedge sys_clk) begin
    if (state == WR) begin
      mem_l[wr_ptr] <= wb_l;
      mem_r[wr_ptr] <= wb_r;
    end
    rd_l <= mem_l[rd_addr];
    rd_r <= mem_r[rd_addr];
  end

  assign del_lx = del_zero ? '0 : {{(PW-WIDTH){rd_l[WIDTH-1]}}, rd_l};
  assign del_rx = del_zero ? '0 : {{(PW-WIDTH){rd_r[WIDTH-1]}}, rd_r};
  assign wet_x  = {{(PW-GAIN_W){1'b0}}, wet_g};
  assign mix_l  = byp ? dry_l : mix(dry_l, pw_l);
  assign mix_r  = byp ? dry_r : mix(dry_r, pw_r);

`ifdef ECHO_FEEDBACK_EN
  logic [GAIN_W-1:0]    fb_g;
  logic signed [PW-1:0] fb_x, pf_l, pf_r;
  assign fb_x = {{(PW-GAIN_W){1'b0}}, fb_g};
  assign wb_l = byp ? dry_l : mix(dry_l, pf_l);
  assign wb_r = byp ? dry_r : mix(dry_r, pf_r);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      fb_g <= '0;
      pf_l <= '0;
      pf_r <= '0;
    end else begin
      if (accept) fb_g <= fb_gain;
      if (state == MAC) begin
        pf_l <= del_lx * fb_x;
        pf_r <= del_rx * fb_x;
      end
    end
  end
`else
  logic unused_fb;
  assign unused_fb = ^fb_gain;
  assign wb_l = dry_l;
  assign wb_r = dry_r;
`endif

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      dry_l     <= '0;
      dry_r     <= '0;
      d_reg     <= '0;
      wet_g     <= '0;
      byp       <= 1'b0;
      rd_addr   <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      del_zero  <= 1'b1;
      pw_l      <= '0;
      pw_r      <= '0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)          overrun <= 1'b0;
      if (accept) begin
        dry_l   <= in_left;
        dry_r   <= in_right;
        d_reg   <= d_in;
        wet_g   <= wet_gain;
        byp     <= bypass;
        rd_addr <= wr_ptr - d_in;
      end
      // History younger than the delay has not been written since reset: read as silence.
      if (state == RD) del_zero <= (fill_cnt < {1'b0, d_reg});
      if (state == MAC) begin
        pw_l <= del_lx * wet_x;
        pw_r <= del_rx * wet_x;
      end
      if (state == WR) begin
        out_left  <= mix_l;
        out_right <= mix_r;
        out_valid <= 1'b1;
        wr_ptr    <= wr_ptr + 1'b1;
        if (!fill_cnt[ADDR_W]) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end
endmodule
